// File: rtl/clk_mon_even.sv
// clk_mon_even: measures high/low phases of a divided clock, flags bad phases, tracks lock and stuck clock.
// Define CLK_MON_SYNC_EN to pass clk_in through a 2-flop synchronizer so it may be asynchronous to clk.
module clk_mon_even #(
  parameter int EXP_HALF = 4,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int WID      = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_in,
  output logic [WID-1:0] half_len,
  output logic           len_vld,
  output logic           err,
  output logic           locked,
  output logic           stuck
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] LC = GW'(LOCK_CNT);
  localparam logic [WID:0] MAX = {1'b0, {WID{1'b1}}};
  localparam logic [WID+1:0] E2 = (WID+2)'(EXP_HALF);
  localparam logic [WID+1:0] T2 = (WID+2)'(TOL);
  typedef enum logic [1:0] {WAIT, MEAS, LOCK} state_t;
  state_t state, state_d;
  logic sig, prev, edg, sat, ok;
  logic [WID-1:0] cnt, len_s, half_d;
  logic [WID:0] len;
  logic [WID+1:0] l2;
  logic [GW-1:0] good, good_d, good_inc;
  logic vld_d, err_d, stuck_d;
`ifdef CLK_MON_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync <= '0;
    else sync <= {sync[0], clk_in};
  assign sig = sync[1];
`else
  assign sig = clk_in;
`endif
  assign edg = sig ^ prev;
  assign sat = cnt == {WID{1'b1}};
  assign len = {1'b0, cnt} + (WID+1)'(1);
  assign len_s = len > MAX ? {WID{1'b1}} : len[WID-1:0];
  // Shifting the lower bound onto the measured side keeps a zero bound from clamping below zero.
  assign l2 = {2'b00, len_s};
  assign ok = (l2 + T2 >= E2) && (l2 <= E2 + T2);
  assign good_inc = good == LC ? good : good + GW'(1);
  always_comb begin
    state_d = state;
    good_d = good;
    stuck_d = stuck;
    vld_d = 1'b0;
    err_d = 1'b0;
    half_d = half_len;
    if (edg) begin
      stuck_d = 1'b0;
      if (state == WAIT) state_d = MEAS;
      else begin
        vld_d = 1'b1;
        half_d = len_s;
        if (ok) begin
          good_d = good_inc;
          if (state == MEAS && good_inc == LC) state_d = LOCK;
        end else begin
          err_d = 1'b1;
          good_d = '0;
          state_d = MEAS;
        end
      end
    end else if (sat) begin
      stuck_d = 1'b1;
      good_d = '0;
      state_d = WAIT;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= WAIT;
      prev <= 1'b0;
      cnt <= '0;
      good <= '0;
      half_len <= '0;
      len_vld <= 1'b0;
      err <= 1'b0;
      locked <= 1'b0;
      stuck <= 1'b0;
    end else begin
      state <= state_d;
      prev <= sig;
      cnt <= edg ? '0 : sat ? cnt : cnt + WID'(1);
      good <= good_d;
      half_len <= half_d;
      len_vld <= vld_d;
      err <= err_d;
      locked <= state_d == LOCK;
      stuck <= stuck_d;
    end
endmodule

// File: tb/tb_clk_mon_even.sv
// tb_clk_mon_even: directed phase sequences against a TOL=0 and a TOL=1 monitor.
module tb_clk_mon_even;
  logic clk = 1'b0, rst = 1'b0, ci0 = 1'b0, ci1 = 1'b0;
  logic [7:0] h0, h1;
  logic v0, e0, l0, s0, v1, e1, l1, s1;
  int n_chk = 0, n_pass = 0, step = 0;
  clk_mon_even dut0 (.clk(clk), .rst(rst), .clk_in(ci0), .half_len(h0), .len_vld(v0), .err(e0), .locked(l0), .stuck(s0));
  clk_mon_even #(.TOL(1)) dut1 (.clk(clk), .rst(rst), .clk_in(ci1), .half_len(h1), .len_vld(v1), .err(e1), .locked(l1), .stuck(s1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  // Toggle clk_in (starting a phase of n cycles), then check the registered result of that edge.
  task automatic ph(input bit s, input int n, input bit ev, input int el, input bit ee, input bit elk);
    step++;
    if (s) ci1 = ~ci1;
    else ci0 = ~ci0;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("len_vld[%0d]", step), s ? v1 : v0, ev);
    if (ev) chk($sformatf("half_len[%0d]", step), s ? h1 : h0, el);
    chk($sformatf("err[%0d]", step), s ? e1 : e0, ee);
    chk($sformatf("locked[%0d]", step), s ? l1 : l0, elk);
    chk($sformatf("stuck[%0d]", step), s ? s1 : s0, 0);
    repeat (n - 1) @(posedge clk);
    #1;
  endtask
  task automatic lock4();
    repeat (3) ph(0, 4, 1, 4, 0, 0);
    ph(0, 4, 1, 4, 0, 1);
  endtask
  initial begin
    #2;
    chk("rst_half_len", h0, 0);
    chk("rst_vld", v0, 0);
    chk("rst_err", e0, 0);
    chk("rst_locked", l0, 0);
    chk("rst_stuck", s0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    ph(0, 4, 0, 0, 0, 0);
    lock4();
    ph(0, 6, 1, 4, 0, 1);
    ph(0, 4, 1, 6, 1, 0);
    lock4();
    repeat (252) @(posedge clk);
    @(negedge clk);
    chk("pre_stuck", s0, 0);
    chk("pre_stuck_locked", l0, 1);
    @(posedge clk);
    @(negedge clk);
    chk("stuck_rise", s0, 1);
    chk("stuck_locked", l0, 0);
    chk("stuck_vld", v0, 0);
    chk("stuck_err", e0, 0);
    @(posedge clk);
    #1;
    ph(0, 4, 0, 0, 0, 0);
    ph(0, 4, 1, 4, 0, 0);
    ph(0, 4, 1, 4, 0, 0);
    ph(0, 256, 1, 4, 0, 0);
    ph(0, 4, 1, 255, 1, 0);
    lock4();
    #2;
    rst = 1'b0;
    ci0 = 1'b0;
    #1;
    chk("arst_half_len", h0, 0);
    chk("arst_locked", l0, 0);
    chk("arst_vld", v0, 0);
    chk("arst_err", e0, 0);
    chk("arst_stuck", s0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    ph(0, 4, 0, 0, 0, 0);
    lock4();
    ph(1, 3, 0, 0, 0, 0);
    ph(1, 5, 1, 3, 0, 0);
    ph(1, 3, 1, 5, 0, 0);
    ph(1, 5, 1, 3, 0, 0);
    ph(1, 6, 1, 5, 0, 1);
    ph(1, 4, 1, 6, 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
